// File: rtl/store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_unit : store-path sequencer (funct3 decode, strobes, bus beats).   |
// | Option macro STORE_UNIT_MISALIGN_SPLIT_EN enables split misaligned store. |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module store_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [XLEN-1:0]       req_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [XLEN/8-1:0]     mem_wstrb,
  output logic                  done,
  output logic                  misalign,
  output logic                  illegal
);

  localparam int c_nb   = XLEN / 8;
  localparam int c_offw = $clog2(c_nb);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_size;
  logic [ADDR_W-1:0]     r_addr;
  logic [XLEN-1:0]       r_data;
  logic                  r_err_illegal;

  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_reject;
  logic [c_offw-1:0]     w_off;
  logic [2*c_nb-1:0]     w_bmask;
  logic [2*c_nb-1:0]     w_wide_strb;
  logic [XLEN-1:0]       w_data_mask;
  logic [2*XLEN-1:0]     w_wide_data;
  logic [ADDR_W-1:0]     w_beat0_addr;
  logic                  w_cross;

  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_illegal = req_funct3[2] || ((req_funct3[1:0] == 2'b11) && (XLEN == 32));

`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
  assign w_reject = w_illegal;
  assign w_cross  = |w_wide_strb[2*c_nb-1:c_nb];
`else
  logic [2:0] w_align_mask;
  always_comb begin
    w_align_mask = 3'b000;
    case (req_funct3[1:0])
      2'b01:   w_align_mask = 3'b001;
      2'b10:   w_align_mask = 3'b011;
      2'b11:   w_align_mask = 3'b111;
      default: w_align_mask = 3'b000;
    endcase
  end
  assign w_reject = w_illegal || (|(req_addr[2:0] & w_align_mask));
  assign w_cross  = 1'b0;
`endif

  // Lane placement works on a double-width word; the upper half is the second beat.
  always_comb begin
    w_bmask = '0;
    case (r_size)
      2'b00:   w_bmask[0]   = 1'b1;
      2'b01:   w_bmask[1:0] = 2'b11;
      2'b10:   w_bmask[3:0] = 4'hF;
      default: w_bmask[7:0] = 8'hFF;
    endcase
    w_data_mask = '0;
    for (int i = 0; i < c_nb; i++) begin
      w_data_mask[8*i +: 8] = {8{w_bmask[i]}};
    end
  end

  assign w_off        = r_addr[c_offw-1:0];
  assign w_wide_strb  = w_bmask << w_off;
  assign w_wide_data  = {{XLEN{1'b0}}, r_data & w_data_mask} << {w_off, 3'b000};
  assign w_beat0_addr = {r_addr[ADDR_W-1:c_offw], {c_offw{1'b0}}};

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    done      = 1'b0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_reject ? ERR : BEAT0;
      end
      BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = w_beat0_addr;
        mem_wdata = w_wide_data[XLEN-1:0];
        mem_wstrb = w_wide_strb[c_nb-1:0];
        if (mem_ready) w_next = w_cross ? BEAT1 : RESP;
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = w_beat0_addr + ADDR_W'(c_nb);
        mem_wdata = w_wide_data[2*XLEN-1:XLEN];
        mem_wstrb = w_wide_strb[2*c_nb-1:c_nb];
        if (mem_ready) w_next = RESP;
      end
      RESP: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      ERR: begin
        illegal  = r_err_illegal;
        misalign = !r_err_illegal;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Outputs read zero for as long as reset is held.
    if (rst) begin
      req_ready = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      done      = 1'b0;
      misalign  = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_size        <= 2'b00;
      r_addr        <= '0;
      r_data        <= '0;
      r_err_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_size        <= req_funct3[1:0];
        r_addr        <= req_addr;
        r_data        <= req_data;
        r_err_illegal <= w_illegal;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_store_unit : checks store_unit at XLEN=32 and XLEN=64 against a       |
// | byte-level reference model. Revision : 1.0                               |
// +--------------------------------------------------------------------------+
module tb_store_unit;

`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
  localparam bit c_split = 1'b1;
`else
  localparam bit c_split = 1'b0;
`endif

  typedef struct {
    int          kind;     // 0 store, 1 misalign, 2 illegal
    int          nbeats;
    logic [31:0] a0;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [7:0]  s0;
    logic [7:0]  s1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [63:0] req_data = 64'd0;
  logic        mem_ready = 1'b0;

  logic        r32_ready, r32_mv, r32_done, r32_mis, r32_ill;
  logic [31:0] r32_addr, r32_wdata;
  logic [3:0]  r32_wstrb;
  logic        r64_ready, r64_mv, r64_done, r64_mis, r64_ill;
  logic [31:0] r64_addr;
  logic [63:0] r64_wdata;
  logic [7:0]  r64_wstrb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  store_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(r32_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data[31:0]),
    .mem_valid(r32_mv), .mem_ready(mem_ready), .mem_addr(r32_addr),
    .mem_wdata(r32_wdata), .mem_wstrb(r32_wstrb), .done(r32_done),
    .misalign(r32_mis), .illegal(r32_ill)
  );

  store_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(r64_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data),
    .mem_valid(r64_mv), .mem_ready(mem_ready), .mem_addr(r64_addr),
    .mem_wdata(r64_wdata), .mem_wstrb(r64_wstrb), .done(r64_done),
    .misalign(r64_mis), .illegal(r64_ill)
  );

  logic        o_ready, o_mv, o_done, o_mis, o_ill;
  logic [31:0] o_addr;
  logic [63:0] o_wdata;
  logic [7:0]  o_wstrb;
  assign o_ready = sel ? r64_ready : r32_ready;
  assign o_mv    = sel ? r64_mv    : r32_mv;
  assign o_done  = sel ? r64_done  : r32_done;
  assign o_mis   = sel ? r64_mis   : r32_mis;
  assign o_ill   = sel ? r64_ill   : r32_ill;
  assign o_addr  = sel ? r64_addr  : r32_addr;
  assign o_wdata = sel ? r64_wdata : {32'h0, r32_wdata};
  assign o_wstrb = sel ? r64_wstrb : {4'h0, r32_wstrb};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Places each store byte individually into the word it lands in.
  function automatic exp_t model(input int nb, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [63:0] data);
    exp_t        e;
    int          sz;
    int          lane;
    logic [31:0] a;
    e.kind = 0; e.nbeats = 0; e.a0 = '0; e.d0 = '0; e.d1 = '0; e.s0 = '0; e.s1 = '0;
    sz = 1 << f3[1:0];
    if (f3[2] || sz > nb) e.kind = 2;
    else if ((addr % sz) != 0 && !c_split) e.kind = 1;
    else begin
      e.nbeats = 1;
      e.a0 = addr - (addr % nb);
      for (int k = 0; k < sz; k++) begin
        a = addr + 32'(k);
        lane = int'(a % nb);
        if (a / nb == addr / nb) begin
          e.s0[lane] = 1'b1;
          e.d0[8*lane +: 8] = data[8*k +: 8];
        end else begin
          e.nbeats = 2;
          e.s1[lane] = 1'b1;
          e.d1[8*lane +: 8] = data[8*k +: 8];
        end
      end
    end
    return e;
  endfunction

  task automatic do_store(input bit s, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] data, input int stall);
    exp_t e;
    int   nb;
    nb = s ? 8 : 4;
    e = model(nb, f3, addr, data);
    sel = s;
    #1;
    chk("idle_ready", 64'(o_ready), 64'd1);
    req_valid = 1'b1; req_funct3 = f3; req_addr = addr; req_data = data;
    tick;
    req_valid = 1'b0;
    #1;
    if (e.kind != 0) begin
      chk("err_mem_valid", 64'(o_mv), 64'd0);
      chk("misalign", 64'(o_mis), 64'(e.kind == 1));
      chk("illegal", 64'(o_ill), 64'(e.kind == 2));
      chk("err_done", 64'(o_done), 64'd0);
      chk("err_ready_low", 64'(o_ready), 64'd0);
      tick;
      chk("err_single_pulse", {62'd0, o_mis, o_ill}, 64'd0);
      chk("ready_after_err", 64'(o_ready), 64'd1);
    end else begin
      for (int b = 0; b < e.nbeats; b++) begin
        for (int k = 0; k <= stall; k++) begin
          chk("mem_valid", 64'(o_mv), 64'd1);
          chk("mem_addr", 64'(o_addr), 64'(b == 0 ? e.a0 : e.a0 + 32'(nb)));
          chk("mem_wdata", o_wdata, b == 0 ? e.d0 : e.d1);
          chk("mem_wstrb", 64'(o_wstrb), 64'(b == 0 ? e.s0 : e.s1));
          chk("busy_no_done", {61'd0, o_done, o_ready, o_mis | o_ill}, 64'd0);
          mem_ready = (k == stall);
          tick;
          mem_ready = 1'b0;
        end
      end
      chk("done", 64'(o_done), 64'd1);
      chk("resp_no_bus", {62'd0, o_mv, o_mis | o_ill}, 64'd0);
      chk("resp_ready_low", 64'(o_ready), 64'd0);
      tick;
      chk("done_single_pulse", 64'(o_done), 64'd0);
      chk("ready_after_done", 64'(o_ready), 64'd1);
    end
  endtask

  initial begin
    int accepts;
    int dones;
    int acc2_cyc;
    int done1_cyc;

    tick;
    tick;
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_outputs", {59'd0, o_mv, o_done, o_mis, o_ill, |o_wstrb}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(o_ready), 64'd1);

    do_store(1'b0, 3'b000, 32'h0000_1003, 64'h0000_0000_0000_00AB, 0);
    do_store(1'b0, 3'b010, 32'h0000_2000, 64'h0000_0000_DEAD_BEEF, 3);
    do_store(1'b0, 3'b001, 32'h0000_1003, 64'h0000_0000_0000_1234, 0);
    do_store(1'b0, 3'b011, 32'h0000_1001, 64'h1111_2222_3333_4444, 0);
    do_store(1'b1, 3'b011, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 0);
    do_store(1'b0, 3'b101, 32'h0000_0004, 64'h0, 0);
    do_store(1'b1, 3'b010, 32'h0000_0016, 64'h0000_0000_CAFE_F00D, 1);

    // Reset in the middle of a stalled beat.
    sel = 1'b0;
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_3000; req_data = 64'h5555_AAAA;
    tick;
    req_valid = 1'b0;
    chk("pre_rst_beat", 64'(o_mv), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_valid", 64'(o_mv), 64'd0);
    chk("rst_mid_ready", 64'(o_ready), 64'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("after_rst_idle", {62'd0, o_ready, o_mv}, 64'd2);
    chk("after_rst_no_done", 64'(o_done), 64'd0);
    tick;
    chk("after_rst_still_no_done", 64'(o_done), 64'd0);
    do_store(1'b0, 3'b010, 32'h0000_3000, 64'h5555_AAAA, 0);

    // Two back-to-back byte stores with req_valid held high.
    sel = 1'b0;
    accepts = 0; dones = 0; acc2_cyc = -1; done1_cyc = -1;
    req_valid = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0000_4001; req_data = 64'h77;
    mem_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (o_done) begin
        dones++;
        if (dones == 1) done1_cyc = cyc;
      end
      if (req_valid && o_ready) begin
        accepts++;
        if (accepts == 2) acc2_cyc = cyc;
      end
      tick;
      if (accepts == 2) req_valid = 1'b0;
    end
    mem_ready = 1'b0;
    chk("b2b_accepts", 64'(accepts), 64'd2);
    chk("b2b_dones", 64'(dones), 64'd2);
    chk("b2b_second_accept", 64'(acc2_cyc), 64'(done1_cyc + 1));

    for (int n = 0; n < 40; n++) begin
      do_store(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               $urandom, {$urandom, $urandom}, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
